// File: rtl/uart_rx_ctrl.sv
// UART receive control FSM.
// Synchronises RXD, detects the start-bit edge, holds the external sample
// counter cleared while idle, and uses its mid-bit RX_CE strobes to validate
// the start bit, shift in data LSB-first and check the stop bit.
//
// Output handshake: RX_VALID is a one-CLK strobe with no ready/backpressure.
// RX_DATA and RX_FERR change only on the edge that raises RX_VALID and hold
// their values until the next stop-bit sample.
module uart_rx_ctrl #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RXD,
    input  logic                 RX_CE,
    output logic                 RXCT_R,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    output logic                 RX_FERR,
    output logic                 RX_BUSY
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shift_q;

    // Control strobes from the next-state logic to the datapath
    logic                   clr_cnt;
    logic                   shift_en;
    logic                   deliver;

    // Synchroniser on the asynchronous serial line; resets to the idle level
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RXD};
        end
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and datapath control strobes
    always_comb begin
        state_d  = state_q;
        clr_cnt  = 1'b0;
        shift_en = 1'b0;
        deliver  = 1'b0;
        case (state_q)
            IDLE: begin
                // RX_CE cannot arrive here: the counter is held cleared
                if (!rxd_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (RX_CE) begin
                    if (!rxd_s) begin
                        state_d = DATA;
                        clr_cnt = 1'b1;
                    end else begin
                        // Start bit did not survive to mid-bit: a glitch
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (RX_CE) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (RX_CE) begin
                    deliver = 1'b1;
                    state_d = rxd_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                // Wait for the line to return high before accepting a start
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bit counter and LSB-first shift register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt <= '0;
            shift_q <= '0;
        end else begin
            if (clr_cnt) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_en) begin
                shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
            end
        end
    end

    // Delivered word, framing flag and one-cycle valid strobe
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RX_DATA  <= '0;
            RX_FERR  <= 1'b0;
            RX_VALID <= 1'b0;
        end else begin
            RX_VALID <= deliver;
            if (deliver) begin
                RX_DATA <= shift_q;
                RX_FERR <= ~rxd_s;
            end
        end
    end

    assign RXCT_R  = (state_q == IDLE) || (state_q == BREAK);
    assign RX_BUSY = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: two instances (8 and 7 data bits), each fed by a
// behavioural 16x sample counter with UART_CE every 4 CLK. Stimulus pushes the
// expected {ferr, data} word into a queue; a monitor pops on RX_VALID.
module tb_uart_rx_ctrl;

    localparam int BIT_CLK = 64;  // 16 UART_CE x 4 CLK

    logic       CLK;
    logic       RST;
    logic [1:0] rxd;
    logic [1:0] rx_ce;
    logic [1:0] rxct_r;
    logic [1:0] rx_valid;
    logic [1:0] rx_ferr;
    logic [1:0] rx_busy;
    logic [7:0] rx_data8;
    logic [6:0] rx_data7;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];
    logic [8:0] last_w0 = '0;

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- DUTs ----------------
    uart_rx_ctrl #(.DATA_BITS(8), .SYNC_STAGES(2)) u_dut8 (
        .CLK(CLK), .RST(RST), .RXD(rxd[0]), .RX_CE(rx_ce[0]),
        .RXCT_R(rxct_r[0]), .RX_DATA(rx_data8), .RX_VALID(rx_valid[0]),
        .RX_FERR(rx_ferr[0]), .RX_BUSY(rx_busy[0])
    );

    uart_rx_ctrl #(.DATA_BITS(7), .SYNC_STAGES(3)) u_dut7 (
        .CLK(CLK), .RST(RST), .RXD(rxd[1]), .RX_CE(rx_ce[1]),
        .RXCT_R(rxct_r[1]), .RX_DATA(rx_data7), .RX_VALID(rx_valid[1]),
        .RX_FERR(rx_ferr[1]), .RX_BUSY(rx_busy[1])
    );

    // ---------------- sample counter model ----------------
    // First RX_CE on the 8th UART_CE after release, then every 16th.
    logic [1:0] pre;
    logic [3:0] sc0;
    logic [3:0] sc1;

    always @(posedge CLK) begin
        if (RST) begin
            pre   <= '0;
            sc0   <= '0;
            sc1   <= '0;
            rx_ce <= '0;
        end else begin
            pre <= pre + 2'd1;
            if (rxct_r[0]) begin
                sc0 <= '0; rx_ce[0] <= 1'b0;
            end else if (pre == 2'd3) begin
                sc0 <= sc0 + 4'd1; rx_ce[0] <= (sc0 == 4'd7);
            end else begin
                rx_ce[0] <= 1'b0;
            end
            if (rxct_r[1]) begin
                sc1 <= '0; rx_ce[1] <= 1'b0;
            end else if (pre == 2'd3) begin
                sc1 <= sc1 + 4'd1; rx_ce[1] <= (sc1 == 4'd7);
            end else begin
                rx_ce[1] <= 1'b0;
            end
        end
    end

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    int         ce_n0 = 0;
    int         ce_n1 = 0;
    logic [1:0] prev_v = '0;

    always @(negedge CLK) begin
        logic [8:0] e;
        if (RST) begin
            ce_n0 = 0; ce_n1 = 0; prev_v = '0;
        end else begin
            if (rx_ce[0]) ce_n0++;
            if (rx_ce[1]) ce_n1++;
            if (rx_valid[0]) begin
                chk("valid8_width", {31'd0, prev_v[0]}, 32'd0);
                if (exp_q0.size() == 0) begin
                    chk("valid8_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q0.pop_front();
                    last_w0 = e;
                    chk("word8", {23'd0, rx_ferr[0], rx_data8}, {23'd0, e});
                    chk("samples8", ce_n0, 32'd10);
                end
            end
            if (rx_valid[1]) begin
                chk("valid7_width", {31'd0, prev_v[1]}, 32'd0);
                if (exp_q1.size() == 0) begin
                    chk("valid7_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q1.pop_front();
                    chk("word7", {23'd0, rx_ferr[1], 1'b0, rx_data7}, {23'd0, e});
                    chk("samples7", ce_n1, 32'd9);
                end
            end
            if (rxct_r[0]) ce_n0 = 0;
            if (rxct_r[1]) ce_n1 = 0;
            prev_v = rx_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input int d, input logic v, input int n);
        rxd[d] = v;
        repeat (n) @(negedge CLK);
    endtask

    // One frame: start, data LSB-first, stop; a low stop bit is followed by
    // extra_low more low CLKs and then the line returns high.
    task automatic send_frame(input int d, input logic [7:0] data, input logic stop,
                              input int extra_low);
        int         nb;
        logic [7:0] m;
        nb = (d == 0) ? 8 : 7;
        m  = (d == 0) ? 8'hFF : 8'h7F;
        if (d == 0) exp_q0.push_back({~stop, data & m});
        else        exp_q1.push_back({~stop, data & m});
        drive_bit(d, 1'b0, BIT_CLK);
        for (int i = 0; i < nb; i++) begin
            drive_bit(d, data[i], BIT_CLK / 2);
            if (i == 0) chk("busy_mid_frame", {31'd0, rx_busy[d]}, 32'd1);
            drive_bit(d, data[i], BIT_CLK / 2);
        end
        drive_bit(d, stop, BIT_CLK);
        if (!stop) begin
            drive_bit(d, 1'b0, extra_low);
            drive_bit(d, 1'b1, 1);
        end
        chk("rxct_after_frame", {31'd0, rxct_r[d]}, 32'd1);
        chk("busy_after_frame", {31'd0, rx_busy[d]}, 32'd0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_rxct"},  {30'd0, rxct_r},   32'd3);
        chk({tag, "_valid"}, {30'd0, rx_valid}, 32'd0);
        chk({tag, "_ferr"},  {30'd0, rx_ferr},  32'd0);
        chk({tag, "_busy"},  {30'd0, rx_busy},  32'd0);
        chk({tag, "_data8"}, {24'd0, rx_data8}, 32'd0);
        chk({tag, "_data7"}, {25'd0, rx_data7}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST = 1'b1;
        rxd = 2'b11;
        repeat (5) @(negedge CLK);
        reset_checks("reset");
        RST = 1'b0;
        repeat (10) @(negedge CLK);

        // 0x55 good stop
        send_frame(0, 8'h55, 1'b1, 0);
        repeat (20) @(negedge CLK);

        // 0x00 then 0xFF back-to-back
        send_frame(0, 8'h00, 1'b1, 0);
        send_frame(0, 8'hFF, 1'b1, 0);
        repeat (20) @(negedge CLK);

        // Glitch: low for 3 UART_CE periods
        drive_bit(0, 1'b0, 12);
        drive_bit(0, 1'b1, 200);
        chk("glitch_data", {24'd0, rx_data8}, {24'd0, last_w0[7:0]});
        chk("glitch_ferr", {31'd0, rx_ferr[0]}, {31'd0, last_w0[8]});
        chk("glitch_rxct", {31'd0, rxct_r[0]}, 32'd1);

        // 0xA3 with framing error, line held low 40 more UART_CE
        send_frame(0, 8'hA3, 1'b0, 160);
        repeat (200) @(negedge CLK);

        // Reset during data bit 4 of 0x3C
        drive_bit(0, 1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) drive_bit(0, (8'h3C >> i) & 1, BIT_CLK);
        drive_bit(0, 1'b1, BIT_CLK / 2);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        reset_checks("midreset");
        RST = 1'b0;
        drive_bit(0, 1'b1, 200);
        send_frame(0, 8'h81, 1'b1, 0);
        repeat (20) @(negedge CLK);

        // 7-bit instance: 0x5A
        send_frame(1, 8'h5A, 1'b1, 0);
        repeat (20) @(negedge CLK);

        // Randomised frames on both instances
        for (int n = 0; n < 30; n++) begin
            int   d;
            logic st;
            d  = $urandom_range(0, 1);
            st = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 5) == 0) begin
                drive_bit(d, 1'b0, $urandom_range(4, 16));
                drive_bit(d, 1'b1, 120);
            end
            send_frame(d, 8'($urandom), st, $urandom_range(0, 100));
            drive_bit(d, 1'b1, st ? $urandom_range(0, 40) : 100);
        end

        // Drain: every pushed word must have been delivered
        for (int t = 0; t < 500 && (exp_q0.size() + exp_q1.size()) != 0; t++)
            @(negedge CLK);
        repeat (20) @(negedge CLK);
        chk("q8_drained", exp_q0.size(), 32'd0);
        chk("q7_drained", exp_q1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
